avalon_mem_model: RTL and testbench
===================================

AVALON_MEM_MODEL -- requirements
Module: avalon_mem_model

Interface
REQ-001 Parameters SHALL be as follows:
- BASE_ADDR, default 32'hBFC00000: byte address that maps to word 0.
- ADDR_BITS, default 14: word-index width; depth = 2^ADDR_BITS words of 32 bits.
- WAIT_CYCLES, default 1, range 0..15: wait states inserted before each access completes.
- INIT_FILE, default "": hex file loaded at time zero; empty string means all memory is zero.
REQ-002 Ports SHALL be as follows:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- address  in  32  byte address from the master.
- read  in  1  read request.
- write  in  1  write request.
- writedata  in  32  write data.
- byteenable  in  4  byte lane enables; bit i enables bits [8i+7:8i].
- readdata  out  32  read data, valid while waitrequest=0 after a read.
- waitrequest  out  1  high = request not yet accepted.
- err  out  1  sticky error flag.
- insp_addr  in  32  backdoor inspect byte address.
- insp_data  out  32  backdoor inspect data.
- rd_count  out  16  completed reads.
- wr_count  out  16  completed writes.
REQ-003 clk SHALL be the only clock; reset SHALL be asynchronous and active-high.

Function
REQ-004 The FSM SHALL have three states: IDLE, WAIT and ACK. waitrequest SHALL be 1 in IDLE and WAIT, and 0 only in ACK.
REQ-005 In IDLE, when read|write=1 at a posedge, the block SHALL latch address, op, writedata and byteenable, load the counter with WAIT_CYCLES, and go to WAIT. Bus inputs after the latch SHALL be ignored until the transfer completes.
REQ-006 In WAIT the counter SHALL decrement each cycle. At the edge where it reads 0, the access SHALL be performed and the state SHALL move to ACK. Total: request seen at edge N -> waitrequest=0 during the cycle after edge N+1+WAIT_CYCLES.
REQ-007 ACK SHALL last exactly one cycle, then return to IDLE. A request held high in ACK SHALL NOT start a new transfer at that edge.
REQ-008 Write: only lanes with byteenable=1 SHALL update; byteenable=0 SHALL complete normally with no memory change.
REQ-009 Read: readdata SHALL equal the full addressed word during ACK and SHALL hold that value until the next completed read.
REQ-010 Word index SHALL be (address-BASE_ADDR)>>2, using modulo-2^32 subtraction.
REQ-011 An address below BASE_ADDR, beyond the top of memory, or with address[1:0]!=0 SHALL still complete the handshake, leave memory unchanged, return readdata=32'hDEADBEEF on a read, and set err.
REQ-012 read=1 and write=1 together SHALL set err and be executed as a write only.
REQ-013 err SHALL stay set until reset.
REQ-014 rd_count/wr_count SHALL increment once per completed transfer (in range or not) and SHALL saturate at 16'hFFFF.
REQ-015 insp_data SHALL be registered: one cycle after insp_addr is sampled it SHALL equal the word at insp_addr, or 0 if out of range. It SHALL NOT interact with the bus FSM.
REQ-016 On a same-edge inspect and bus write to one word, insp_data SHALL show the pre-write value.

Reset
REQ-017 Reset SHALL force, immediately:
- state = IDLE
- waitrequest = 1
- readdata = 0
- insp_data = 0
- err = 0
- rd_count = wr_count = 0
- counter = 0
REQ-018 Reset in the middle of a transfer SHALL abort it with no memory update. Memory contents SHALL be preserved across reset; INIT_FILE SHALL be loaded only at time zero.

Verification
REQ-019 Set WAIT_CYCLES=2. Write 32'h12345678 to 0xBFC00400 with be=4'hF, then read it back -> waitrequest=0 exactly 3 cycles after the request is sampled; readdata=32'h12345678; wr_count=1, rd_count=1.
REQ-020 Write 32'hAABBCCDD with be=4'b0101 over a word holding 0 -> the word reads 32'h00BB00DD. A write with be=0 leaves it unchanged.
REQ-021 Read 0xBFBFFFFC, then 0xBFC00002 -> each completes; readdata=32'hDEADBEEF; err=1 and stays 1; memory unchanged.
REQ-022 Assert read+write to 0xBFC00010 with 32'h1 -> err=1, the word becomes 32'h1, wr_count increments and rd_count does not.
REQ-023 Assert reset during WAIT of a write -> waitrequest=1 at once, the target word is unchanged, and the counts are 0. Earlier written data is still readable, both by the bus and via insp_data one cycle after insp_addr.
REQ-024 Set WAIT_CYCLES=0 and issue 70000 back-to-back reads -> each completes in 2 cycles and rd_count saturates at 16'hFFFF.

Source files
------------

// File: rtl/avalon_mem_model.sv
// -----------------------------------------------------------------------------
// avalon_mem_model
//   Behavioural-but-synthesizable Avalon-MM slave memory: 2^ADDR_BITS words of
//   32 bits mapped at BASE_ADDR. Each access inserts WAIT_CYCLES wait states
//   and then completes with a single-cycle acknowledge (waitrequest low).
//   Out-of-map, misaligned and read+write collisions are reported on a sticky
//   err flag. A side-band inspect port reads memory without touching the bus.
//
// Ports
//   clk          clock
//   reset        asynchronous, active-high reset
//   address      byte address from the master
//   read/write   request strobes (both high = write, flagged as an error)
//   writedata    write data
//   byteenable   lane enables, bit i covers bits [8i+7:8i]
//   readdata     read data, valid while waitrequest=0 after a read, then held
//   waitrequest  high until the request is accepted (low only in ACK)
//   err          sticky error flag, cleared only by reset
//   insp_addr    backdoor inspect byte address
//   insp_data    registered backdoor data (0 for out-of-map addresses)
//   rd_count     completed reads, saturating
//   wr_count     completed writes, saturating
// -----------------------------------------------------------------------------
module avalon_mem_model #(
    parameter logic [31:0] BASE_ADDR   = 32'hBFC00000,
    parameter int          ADDR_BITS   = 14,
    parameter int          WAIT_CYCLES = 1,
    parameter string       INIT_FILE   = ""
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] address,
    input  logic        read,
    input  logic        write,
    input  logic [31:0] writedata,
    input  logic [3:0]  byteenable,
    output logic [31:0] readdata,
    output logic        waitrequest,
    output logic        err,
    input  logic [31:0] insp_addr,
    output logic [31:0] insp_data,
    output logic [15:0] rd_count,
    output logic [15:0] wr_count
);

    localparam int DEPTH = 1 << ADDR_BITS;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        ACK
    } state_t;

    typedef struct packed {
        logic                 ok;
        logic [ADDR_BITS-1:0] idx;
    } decode_t;

    // Byte address -> word index. The subtraction wraps modulo 2^32, so an
    // address below BASE_ADDR lands far above the top of memory and fails the
    // range test along with genuinely high addresses.
    function automatic decode_t decode(input logic [31:0] byte_addr);
        logic [31:0] offset;
        decode_t     d;
        offset = byte_addr - BASE_ADDR;
        d.ok   = (byte_addr[1:0] == 2'b00) && ((offset >> (ADDR_BITS + 2)) == 32'd0);
        d.idx  = offset[ADDR_BITS+1:2];
        return d;
    endfunction

    logic [31:0] mem [0:DEPTH-1];

    state_t      state;
    state_t      next_state;
    logic        access;
    logic [3:0]  count;

    // Transfer captured at acceptance; the bus is ignored until it completes.
    logic [31:0] lat_addr;
    logic        lat_write;
    logic        lat_conflict;
    logic [31:0] lat_wdata;
    logic [3:0]  lat_be;

    decode_t     bus_dec;
    decode_t     insp_dec;

    always_comb begin
        bus_dec  = decode(lat_addr);
        insp_dec = decode(insp_addr);
    end

    // Contents are established once at time zero and survive reset.
    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            mem[i] = '0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of block evaluation order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // NOTE: every output of this block is given a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        next_state  = state;
        waitrequest = 1'b1;
        access      = 1'b0;
        case (state)
            IDLE: begin
                if (read || write) begin
                    next_state = WAIT;
                end
            end
            WAIT: begin
                if (count == 4'd0) begin
                    next_state = ACK;
                    access     = 1'b1;
                end
            end
            ACK: begin
                // Leaves unconditionally: a request still high here is only
                // looked at again once back in IDLE.
                next_state  = IDLE;
                waitrequest = 1'b0;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count        <= '0;
            readdata     <= '0;
            err          <= 1'b0;
            rd_count     <= '0;
            wr_count     <= '0;
            lat_addr     <= '0;
            lat_write    <= 1'b0;
            lat_conflict <= 1'b0;
            lat_wdata    <= '0;
            lat_be       <= '0;
        end else begin
            if (state == IDLE && (read || write)) begin
                lat_addr     <= address;
                lat_write    <= write;
                lat_conflict <= read && write;
                lat_wdata    <= writedata;
                lat_be       <= byteenable;
                count        <= 4'(WAIT_CYCLES);
            end else if (state == WAIT && count != 4'd0) begin
                count <= count - 4'd1;
            end

            if (access) begin
                if (!bus_dec.ok || lat_conflict) begin
                    err <= 1'b1;
                end
                if (lat_write) begin
                    if (wr_count != 16'hFFFF) begin
                        wr_count <= wr_count + 16'd1;
                    end
                end else begin
                    readdata <= bus_dec.ok ? mem[bus_dec.idx] : 32'hDEADBEEF;
                    if (rd_count != 16'hFFFF) begin
                        rd_count <= rd_count + 16'd1;
                    end
                end
            end
        end
    end

    // NOTE: the array has no reset so it maps onto RAM and keeps its contents
    // across reset; a reset mid-transfer forces IDLE, which kills 'access'.
    always_ff @(posedge clk) begin
        if (access && lat_write && bus_dec.ok) begin
            for (int i = 0; i < 4; i++) begin
                if (lat_be[i]) begin
                    mem[bus_dec.idx][8*i +: 8] <= lat_wdata[8*i +: 8];
                end
            end
        end
    end

    // Registered read shares the same edge as a bus write, so a same-edge
    // write to the inspected word shows up one cycle later.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            insp_data <= '0;
        end else begin
            insp_data <= insp_dec.ok ? mem[insp_dec.idx] : 32'h0;
        end
    end

endmodule

// File: tb/tb_avalon_mem_model.sv
// -----------------------------------------------------------------------------
// tb_avalon_mem_model
//   Directed + randomized bench for avalon_mem_model. Expected values come
//   from a transaction-level model: a sparse byte-addressed word map, a sticky
//   error bit and saturating counters. A second instance with no wait states
//   covers the back-to-back timing and counter saturation.
// -----------------------------------------------------------------------------
module tb_avalon_mem_model;

    localparam logic [31:0] BASE  = 32'hBFC00000;
    localparam int          ABITS = 14;
    localparam int          WAITC = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] address, writedata, insp_addr;
    logic        read, write;
    logic [3:0]  byteenable;
    logic [31:0] readdata, insp_data;
    logic        waitrequest, err;
    logic [15:0] rd_count, wr_count;

    logic [31:0] s0_address, s0_writedata, s0_insp_addr;
    logic        s0_read, s0_write;
    logic [3:0]  s0_byteenable;
    logic [31:0] s0_readdata, s0_insp_data;
    logic        s0_waitrequest, s0_err;
    logic [15:0] s0_rd_count, s0_wr_count;

    always #5 clk = ~clk;

    avalon_mem_model #(
        .BASE_ADDR(BASE), .ADDR_BITS(ABITS), .WAIT_CYCLES(WAITC), .INIT_FILE("")
    ) dut (
        .clk(clk), .reset(reset), .address(address), .read(read), .write(write),
        .writedata(writedata), .byteenable(byteenable), .readdata(readdata),
        .waitrequest(waitrequest), .err(err), .insp_addr(insp_addr),
        .insp_data(insp_data), .rd_count(rd_count), .wr_count(wr_count)
    );

    avalon_mem_model #(
        .BASE_ADDR(BASE), .ADDR_BITS(ABITS), .WAIT_CYCLES(0), .INIT_FILE("")
    ) dut0 (
        .clk(clk), .reset(reset), .address(s0_address), .read(s0_read), .write(s0_write),
        .writedata(s0_writedata), .byteenable(s0_byteenable), .readdata(s0_readdata),
        .waitrequest(s0_waitrequest), .err(s0_err), .insp_addr(s0_insp_addr),
        .insp_data(s0_insp_data), .rd_count(s0_rd_count), .wr_count(s0_wr_count)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state.
    logic [31:0] model_mem [int unsigned];
    bit          exp_err;
    logic [15:0] exp_rd, exp_wr, exp0_rd;
    logic [31:0] exp_rdata;
    logic [31:0] insp_at_ack;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit in_map(input logic [31:0] a);
        longint unsigned ua, lo, hi;
        ua = a;
        lo = BASE;
        hi = lo + 4 * (longint'(1) << ABITS);
        return (ua % 4 == 0) && (ua >= lo) && (ua < hi);
    endfunction

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        return model_mem.exists(a) ? model_mem[a] : 32'h0;
    endfunction

    task automatic model_xfer(input logic rd, input logic wr, input logic [31:0] a,
                              input logic [31:0] d, input logic [3:0] be);
        logic [31:0] w;
        if (!in_map(a) || (rd && wr)) exp_err = 1'b1;
        if (wr) begin
            if (in_map(a)) begin
                w = mem_rd(a);
                for (int i = 0; i < 4; i++) if (be[i]) w[8*i +: 8] = d[8*i +: 8];
                model_mem[a] = w;
            end
            if (exp_wr != 16'hFFFF) exp_wr++;
        end else begin
            exp_rdata = in_map(a) ? mem_rd(a) : 32'hDEADBEEF;
            if (exp_rd != 16'hFFFF) exp_rd++;
        end
    endtask

    // Counts edges after the request edge until waitrequest drops (bounded).
    task automatic wait_ack(output int lat);
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (waitrequest !== 1'b0 && lat < 40);
    endtask

    // One full transfer on dut; entered and left #1 after a posedge in IDLE.
    task automatic xfer(input logic rd, input logic wr, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] be, input string tag);
        int lat;
        read = rd; write = wr; address = a; writedata = d; byteenable = be;
        @(posedge clk); #1;
        // Garbage on the bus after acceptance must not affect the transfer.
        read = 1'b0; write = 1'b0;
        address = $urandom; writedata = $urandom; byteenable = 4'($urandom);
        model_xfer(rd, wr, a, d, be);
        wait_ack(lat);
        check({tag, ".latency"}, 32'(lat), 32'(WAITC + 1));
        check({tag, ".readdata"}, readdata, exp_rdata);
        check({tag, ".err"}, 32'(err), 32'(exp_err));
        check({tag, ".rd_count"}, 32'(rd_count), 32'(exp_rd));
        check({tag, ".wr_count"}, 32'(wr_count), 32'(exp_wr));
        insp_at_ack = insp_data;
        @(posedge clk); #1;
        check({tag, ".ack_one_cycle"}, 32'(waitrequest), 32'd1);
    endtask

    // Back-to-back reads on the zero-wait instance.
    task automatic s0_reads(input int n);
        for (int i = 0; i < n; i++) begin
            s0_read = 1'b1;
            s0_address = BASE + 32'(4 * $urandom_range(0, 1023));
            @(posedge clk); #1;
            s0_read = 1'b0;
            if (exp0_rd != 16'hFFFF) exp0_rd++;
            @(posedge clk); #1;
            check("w0.wait_low", 32'(s0_waitrequest), 32'd0);
            check("w0.readdata", s0_readdata, 32'h0);
            check("w0.rd_count", 32'(s0_rd_count), 32'(exp0_rd));
            @(posedge clk); #1;
            check("w0.ack_one_cycle", 32'(s0_waitrequest), 32'd1);
        end
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] a, d, old;
        int          lat;

        reset = 1'b1;
        read = 1'b0; write = 1'b0; address = '0; writedata = '0; byteenable = '0;
        insp_addr = BASE;
        s0_read = 1'b0; s0_write = 1'b0; s0_address = BASE; s0_writedata = '0;
        s0_byteenable = '0; s0_insp_addr = BASE;
        exp_err = 1'b0; exp_rd = '0; exp_wr = '0; exp0_rd = '0; exp_rdata = '0;

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        check("rst.waitrequest", 32'(waitrequest), 32'd1);
        check("rst.readdata", readdata, 32'h0);
        check("rst.insp_data", insp_data, 32'h0);
        check("rst.err", 32'(err), 32'd0);
        check("rst.rd_count", 32'(rd_count), 32'd0);
        check("rst.wr_count", 32'(wr_count), 32'd0);
        reset = 1'b0;

        // Basic write/read-back with two wait states.
        xfer(1'b0, 1'b1, 32'hBFC00400, 32'h12345678, 4'hF, "wr400");
        xfer(1'b1, 1'b0, 32'hBFC00400, 32'h0, 4'h0, "rd400");
        check("rd400.value", readdata, 32'h12345678);
        check("rd400.wr_total", 32'(wr_count), 32'd1);
        check("rd400.rd_total", 32'(rd_count), 32'd1);

        // Partial lanes over a zero word, then a no-lane write.
        xfer(1'b0, 1'b1, 32'hBFC00800, 32'hAABBCCDD, 4'b0101, "wr_be5");
        xfer(1'b1, 1'b0, 32'hBFC00800, 32'h0, 4'h0, "rd_be5");
        check("be5.value", readdata, 32'h00BB00DD);
        xfer(1'b0, 1'b1, 32'hBFC00800, 32'h11223344, 4'h0, "wr_be0");
        xfer(1'b1, 1'b0, 32'hBFC00800, 32'h0, 4'h0, "rd_be0");
        check("be0.value", readdata, 32'h00BB00DD);

        // Request held high through ACK must yield exactly one transfer.
        read = 1'b1; write = 1'b0; address = 32'hBFC00400;
        @(posedge clk); #1;
        model_xfer(1'b1, 1'b0, 32'hBFC00400, 32'h0, 4'h0);
        wait_ack(lat);
        check("hold.latency", 32'(lat), 32'(WAITC + 1));
        @(posedge clk); #1;
        read = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        check("hold.rd_count", 32'(rd_count), 32'(exp_rd));
        check("hold.idle", 32'(waitrequest), 32'd1);

        // Last word of the map is in range.
        xfer(1'b0, 1'b1, 32'hBFC0FFFC, $urandom, 4'hF, "wr_top");
        xfer(1'b1, 1'b0, 32'hBFC0FFFC, 32'h0, 4'h0, "rd_top");

        // Randomized in-range traffic with backdoor checks.
        for (int i = 0; i < 30; i++) begin
            a = BASE + 32'(4 * $urandom_range(0, 31));
            insp_addr = BASE + 32'(4 * $urandom_range(0, 31));
            if ($urandom_range(0, 1) == 0)
                xfer(1'b1, 1'b0, a, $urandom, 4'($urandom), "rand_rd");
            else
                xfer(1'b0, 1'b1, a, $urandom, 4'($urandom_range(0, 15)), "rand_wr");
            check("rand.insp", insp_data, mem_rd(insp_addr));
        end

        // Inspect and bus write hitting the same word on the same edge.
        insp_addr = 32'hBFC00020;
        old = mem_rd(32'hBFC00020);
        d = ~old;
        xfer(1'b0, 1'b1, 32'hBFC00020, d, 4'hF, "same_edge");
        check("same_edge.insp_pre", insp_at_ack, old);
        check("same_edge.insp_post", insp_data, d);

        // Error cases: below base, misaligned, above top.
        xfer(1'b1, 1'b0, 32'hBFBFFFFC, 32'h0, 4'h0, "rd_below");
        check("rd_below.value", readdata, 32'hDEADBEEF);
        check("rd_below.err", 32'(err), 32'd1);
        xfer(1'b1, 1'b0, 32'hBFC00002, 32'h0, 4'h0, "rd_misal");
        check("rd_misal.value", readdata, 32'hDEADBEEF);
        xfer(1'b0, 1'b1, 32'hBFC10000, 32'hCAFEF00D, 4'hF, "wr_above");
        xfer(1'b0, 1'b1, 32'hBFC00402, 32'hCAFEF00D, 4'hF, "wr_misal");
        insp_addr = BASE;
        @(posedge clk); #1;
        check("wr_above.no_alias", insp_data, mem_rd(BASE));
        xfer(1'b1, 1'b0, 32'hBFC00400, 32'h0, 4'h0, "rd400_after_err");
        check("err.sticky", 32'(err), 32'd1);

        // Read and write together: executes as a write.
        xfer(1'b1, 1'b1, 32'hBFC00010, 32'h1, 4'hF, "rdwr");
        xfer(1'b1, 1'b0, 32'hBFC00010, 32'h0, 4'h0, "rdwr_back");
        check("rdwr.value", readdata, 32'h1);

        // Reset during WAIT of a write aborts it.
        insp_addr = 32'hBFC00400;
        old = mem_rd(32'hBFC00400);
        read = 1'b0; write = 1'b1; address = 32'hBFC00400; writedata = ~old; byteenable = 4'hF;
        @(posedge clk); #1;
        write = 1'b0;
        @(posedge clk); #3;
        reset = 1'b1;
        #1;
        check("abort.waitrequest", 32'(waitrequest), 32'd1);
        check("abort.readdata", readdata, 32'h0);
        check("abort.rd_count", 32'(rd_count), 32'd0);
        check("abort.wr_count", 32'(wr_count), 32'd0);
        check("abort.err", 32'(err), 32'd0);
        exp_err = 1'b0; exp_rd = '0; exp_wr = '0; exp_rdata = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk); #1;
        check("abort.insp", insp_data, old);
        xfer(1'b1, 1'b0, 32'hBFC00400, 32'h0, 4'h0, "abort_rd");
        check("abort.bus_value", readdata, old);

        // Zero wait states: two-cycle completion, then saturation.
        s0_reads(20);
        check("w0.wr_count", 32'(s0_wr_count), 32'd0);
        check("w0.insp", s0_insp_data, 32'h0);
        // Jump the read counter near its ceiling so saturation is reached
        // within a handful of transfers.
        force dut0.rd_count = 16'hFFF8;
        #1;
        release dut0.rd_count;
        exp0_rd = 16'hFFF8;
        s0_reads(12);
        check("w0.saturated", 32'(s0_rd_count), 32'h0000FFFF);
        check("w0.err", 32'(s0_err), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
